// File: rtl/rv32_decode_pkg.sv
// Shared types and encodings for the RV32 decode stage: micro-op codes,
// immediate formats, skid-buffer states and the immediate extraction helper.
package rv32_decode_pkg;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_ILLEGAL
  } rv32_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] imm;
    logic        illegal;
  } uop_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic logic [31:0] rv32_imm(input imm_fmt_t fmt, input logic [31:0] instr);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I/E instruction decoder. Register indices of
// fields the format does not use are reported as 0, as is everything on illegal.
module rv32_decode_comb
  import rv32_decode_pkg::*;
#(
  parameter bit RV32E         = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic [31:0] i_instr,
  output logic [5:0]  o_op,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_rd_write,
  output logic [31:0] o_imm,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [4:0] w_rs1_f;
  logic [4:0] w_rs2_f;
  logic [4:0] w_rd_f;

  assign w_opcode = i_instr[6:0];
  assign w_rd_f   = i_instr[11:7];
  assign w_f3     = i_instr[14:12];
  assign w_rs1_f  = i_instr[19:15];
  assign w_rs2_f  = i_instr[24:20];
  assign w_f7     = i_instr[31:25];

  rv32_op_t w_op;
  imm_fmt_t w_fmt;
  logic     w_use_rs1;
  logic     w_use_rs2;
  logic     w_use_rd;
  logic     w_legal;
  logic     w_bad_reg;
  logic     w_illegal;

  always_comb begin
    w_op      = OP_ILLEGAL;
    w_fmt     = IMM_NONE;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_legal   = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_op = OP_LUI; w_fmt = IMM_U; w_use_rd = 1'b1; w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_op = OP_AUIPC; w_fmt = IMM_U; w_use_rd = 1'b1; w_legal = 1'b1;
      end
      OPC_JAL: begin
        w_op = OP_JAL; w_fmt = IMM_J; w_use_rd = 1'b1; w_legal = 1'b1;
      end
      OPC_JALR: begin
        w_op = OP_JALR; w_fmt = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_legal = (w_f3 == 3'b000);
      end
      OPC_BRANCH: begin
        w_fmt = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_legal = 1'b1;
        case (w_f3)
          F3_BEQ:  w_op = OP_BEQ;
          F3_BNE:  w_op = OP_BNE;
          F3_BLT:  w_op = OP_BLT;
          F3_BGE:  w_op = OP_BGE;
          F3_BLTU: w_op = OP_BLTU;
          F3_BGEU: w_op = OP_BGEU;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_fmt = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_legal = 1'b1;
        case (w_f3)
          F3_B:    w_op = OP_LB;
          F3_H:    w_op = OP_LH;
          F3_W:    w_op = OP_LW;
          F3_BU:   w_op = OP_LBU;
          F3_HU:   w_op = OP_LHU;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_fmt = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_legal = 1'b1;
        case (w_f3)
          F3_B:    w_op = OP_SB;
          F3_H:    w_op = OP_SH;
          F3_W:    w_op = OP_SW;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        w_fmt = IMM_I; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_legal = 1'b1;
        case (w_f3)
          F3_ADD:  w_op = OP_ADDI;
          F3_SLT:  w_op = OP_SLTI;
          F3_SLTU: w_op = OP_SLTIU;
          F3_XOR:  w_op = OP_XORI;
          F3_OR:   w_op = OP_ORI;
          F3_AND:  w_op = OP_ANDI;
          F3_SLL: begin
            w_op    = OP_SLLI;
            w_legal = (w_f7 == F7_BASE);
          end
          default: begin
            if (w_f7 == F7_BASE)     w_op = OP_SRLI;
            else if (w_f7 == F7_ALT) w_op = OP_SRAI;
            else                     w_legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; w_legal = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            F3_ADD:  w_op = OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = OP_SRL;
            F3_OR:   w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          case (w_f3)
            F3_ADD:  w_op = OP_SUB;
            F3_SR:   w_op = OP_SRA;
            default: w_legal = 1'b0;
          endcase
        end else begin
          w_legal = 1'b0;
        end
      end
      OPC_MISC_MEM: begin
        w_op    = OP_FENCE;
        w_legal = ENABLE_SYSTEM && (w_f3 == 3'b000);
      end
      OPC_SYSTEM: begin
        if (i_instr == INSTR_ECALL) begin
          w_op    = OP_ECALL;
          w_legal = ENABLE_SYSTEM;
        end else if (i_instr == INSTR_EBREAK) begin
          w_op    = OP_EBREAK;
          w_legal = ENABLE_SYSTEM;
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Only fields the format really uses are range-checked, so immediates
  // overlapping the rs2 slot cannot trip the RV32E limit.
  assign w_bad_reg = RV32E && ((w_use_rs1 && w_rs1_f[4]) ||
                               (w_use_rs2 && w_rs2_f[4]) ||
                               (w_use_rd  && w_rd_f[4]));
  assign w_illegal = !w_legal || w_bad_reg;

  assign o_illegal  = w_illegal;
  assign o_op       = w_illegal ? OP_ILLEGAL : w_op;
  assign o_rs1      = (!w_illegal && w_use_rs1) ? w_rs1_f : 5'd0;
  assign o_rs2      = (!w_illegal && w_use_rs2) ? w_rs2_f : 5'd0;
  assign o_rd       = (!w_illegal && w_use_rd)  ? w_rd_f  : 5'd0;
  assign o_rd_write = !w_illegal && w_use_rd && (w_rd_f != 5'd0);
  assign o_imm      = w_illegal ? 32'd0 : rv32_imm(w_fmt, i_instr);

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: valid/ready on both sides with a two-entry skid buffer
// (output register + skid register), flush, and registered in_ready.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter bit RV32E         = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_pc,
  input  logic [31:0] i_in_instr,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_pc,
  output logic [5:0]  o_out_op,
  output logic [4:0]  o_out_rs1,
  output logic [4:0]  o_out_rs2,
  output logic [4:0]  o_out_rd,
  output logic        o_out_rd_write,
  output logic [31:0] o_out_imm,
  output logic        o_out_illegal
);

  logic [5:0]  w_dec_op;
  logic [4:0]  w_dec_rs1;
  logic [4:0]  w_dec_rs2;
  logic [4:0]  w_dec_rd;
  logic        w_dec_rd_write;
  logic [31:0] w_dec_imm;
  logic        w_dec_illegal;
  uop_t        w_dec;

  rv32_decode_comb #(
    .RV32E         (RV32E),
    .ENABLE_SYSTEM (ENABLE_SYSTEM)
  ) u_comb (
    .i_instr    (i_in_instr),
    .o_op       (w_dec_op),
    .o_rs1      (w_dec_rs1),
    .o_rs2      (w_dec_rs2),
    .o_rd       (w_dec_rd),
    .o_rd_write (w_dec_rd_write),
    .o_imm      (w_dec_imm),
    .o_illegal  (w_dec_illegal)
  );

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = i_in_pc;
    w_dec.op       = w_dec_op;
    w_dec.rs1      = w_dec_rs1;
    w_dec.rs2      = w_dec_rs2;
    w_dec.rd       = w_dec_rd;
    w_dec.rd_write = w_dec_rd_write;
    w_dec.imm      = w_dec_imm;
    w_dec.illegal  = w_dec_illegal;
  end

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  uop_t        r_out;
  uop_t        r_skid;
  logic        r_in_ready;
  logic        w_accept;
  logic        w_fire;
  logic        w_load_out_in;
  logic        w_load_out_skid;
  logic        w_load_skid;

  assign w_accept = i_in_valid && r_in_ready && !i_flush;
  assign w_fire   = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (i_flush) begin
      w_state_nxt = SKID_EMPTY;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            w_state_nxt   = SKID_ONE;
            w_load_out_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_fire) begin
            w_load_out_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = SKID_TWO;
            w_load_skid = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_fire) begin
            w_state_nxt     = SKID_ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: w_state_nxt = SKID_EMPTY;
      endcase
    end
  end

  // in_ready is a flop derived from the next state, so out_ready never
  // reaches it combinationally; it is low exactly while both entries are full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != SKID_TWO);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_in) begin
        r_out <= w_dec;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = (r_state != SKID_EMPTY);
  assign o_out_pc       = r_out.pc;
  assign o_out_op       = r_out.op;
  assign o_out_rs1      = r_out.rs1;
  assign o_out_rs2      = r_out.rs2;
  assign o_out_rd       = r_out.rd;
  assign o_out_rd_write = r_out.rd_write;
  assign o_out_imm      = r_out.imm;
  assign o_out_illegal  = r_out.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: a scoreboard queue of expected micro-ops
// is filled on accept and drained on output fire; a second instance runs RV32E.
module tb_rv32_decode_stage;
  import rv32_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] in_instr = 32'd0;

  logic        a_in_ready, a_out_valid, a_rd_write, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [5:0]  a_op;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  logic        b_in_ready, b_out_valid, b_rd_write, b_illegal;
  logic [31:0] b_out_pc, b_imm;
  logic [5:0]  b_op;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  always #5 clk = ~clk;

  rv32_decode_stage #(.RV32E(1'b0), .ENABLE_SYSTEM(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(a_in_ready),
    .i_in_pc(in_pc), .i_in_instr(in_instr),
    .o_out_valid(a_out_valid), .i_out_ready(out_ready),
    .o_out_pc(a_out_pc), .o_out_op(a_op),
    .o_out_rs1(a_rs1), .o_out_rs2(a_rs2), .o_out_rd(a_rd),
    .o_out_rd_write(a_rd_write), .o_out_imm(a_imm), .o_out_illegal(a_illegal)
  );

  rv32_decode_stage #(.RV32E(1'b1), .ENABLE_SYSTEM(1'b1)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(b_in_ready),
    .i_in_pc(in_pc), .i_in_instr(in_instr),
    .o_out_valid(b_out_valid), .i_out_ready(1'b1),
    .o_out_pc(b_out_pc), .o_out_op(b_op),
    .o_out_rs1(b_rs1), .o_out_rs2(b_rs2), .o_out_rd(b_rd),
    .o_out_rd_write(b_rd_write), .o_out_imm(b_imm), .o_out_illegal(b_illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] imm;
    logic        illegal;
    bit          chk_rs1;
    bit          chk_rs2;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  exp_t vecs[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops = 0;
  int   pops_base;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input rv32_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rdw, input logic [31:0] imm,
                              input logic ill, input bit c1, input bit c2, input bit cd);
    exp_t e;
    e.pc = pc; e.instr = instr; e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.rd_write = rdw; e.imm = imm; e.illegal = ill;
    e.chk_rs1 = c1; e.chk_rs2 = c2; e.chk_rd = cd;
    return e;
  endfunction

  task automatic offer(input exp_t e);
    cur      = e;
    in_pc    = e.pc;
    in_instr = e.instr;
    in_valid = 1'b1;
  endtask

  // Sampled mid-cycle: these are the values the next rising edge acts on.
  task automatic monitor();
    exp_t e;
    last_acc = 1'b0;
    if (!rst_n) return;
    if (flush) begin
      sb.delete();
      return;
    end
    if (a_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", {31'd0, a_out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        n_pops++;
        chk("out_pc", a_out_pc, e.pc);
        chk("out_op", {26'd0, a_op}, {26'd0, e.op});
        chk("out_rd_write", {31'd0, a_rd_write}, {31'd0, e.rd_write});
        chk("out_imm", a_imm, e.imm);
        chk("out_illegal", {31'd0, a_illegal}, {31'd0, e.illegal});
        if (e.chk_rs1) chk("out_rs1", {27'd0, a_rs1}, {27'd0, e.rs1});
        if (e.chk_rs2) chk("out_rs2", {27'd0, a_rs2}, {27'd0, e.rs2});
        if (e.chk_rd)  chk("out_rd", {27'd0, a_rd}, {27'd0, e.rd});
      end
    end
    if (in_valid && a_in_ready) begin
      sb.push_back(cur);
      last_acc = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_pc", a_out_pc, 32'd0);
    chk("rst_out_imm", a_imm, 32'd0);
    chk("rst_out_op", {26'd0, a_op}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // Single LUI: one-cycle latency from accept.
    offer(mk(32'h100, 32'h123450B7, OP_LUI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h12345000, 1'b0, 0, 0, 1));
    cycle();
    in_valid = 1'b0;
    chk("lui_latency_out_valid", {31'd0, a_out_valid}, 32'd1);
    cycle();
    chk("lui_popped", n_pops, 1);

    // Back-to-back burst with out_ready high.
    vecs.push_back(mk(32'h200, 32'hFFF00093, OP_ADDI,    5'd0, 5'd0, 5'd1,  1'b1, 32'hFFFFFFFF, 1'b0, 1, 0, 1));
    vecs.push_back(mk(32'h204, 32'h40101093, OP_ILLEGAL, 5'd0, 5'd0, 5'd0,  1'b0, 32'h0,        1'b1, 0, 0, 0));
    vecs.push_back(mk(32'h208, 32'h0020A423, OP_SW,      5'd1, 5'd2, 5'd0,  1'b0, 32'h8,        1'b0, 1, 1, 0));
    vecs.push_back(mk(32'h20C, 32'hFE000EE3, OP_BEQ,     5'd0, 5'd0, 5'd0,  1'b0, 32'hFFFFFFFC, 1'b0, 0, 0, 0));
    vecs.push_back(mk(32'h210, 32'h008000EF, OP_JAL,     5'd0, 5'd0, 5'd1,  1'b1, 32'h8,        1'b0, 0, 0, 1));
    vecs.push_back(mk(32'h214, 32'h00000013, OP_ADDI,    5'd0, 5'd0, 5'd0,  1'b0, 32'h0,        1'b0, 0, 0, 1));
    vecs.push_back(mk(32'h218, 32'h00000073, OP_ECALL,   5'd0, 5'd0, 5'd0,  1'b0, 32'h0,        1'b0, 0, 0, 0));
    vecs.push_back(mk(32'h21C, 32'h4030D093, OP_SRAI,    5'd1, 5'd0, 5'd1,  1'b1, 32'h403,      1'b0, 1, 0, 1));
    vecs.push_back(mk(32'h220, 32'h402081B3, OP_SUB,     5'd1, 5'd2, 5'd3,  1'b1, 32'h0,        1'b0, 1, 1, 1));
    vecs.push_back(mk(32'h224, 32'h00009067, OP_ILLEGAL, 5'd0, 5'd0, 5'd0,  1'b0, 32'h0,        1'b1, 0, 0, 0));
    vecs.push_back(mk(32'h228, 32'h80000297, OP_AUIPC,   5'd0, 5'd0, 5'd5,  1'b1, 32'h80000000, 1'b0, 0, 0, 1));
    vecs.push_back(mk(32'h22C, 32'hFF812303, OP_LW,      5'd2, 5'd0, 5'd6,  1'b1, 32'hFFFFFFF8, 1'b0, 1, 0, 1));
    vecs.push_back(mk(32'h230, 32'h0000000F, OP_FENCE,   5'd0, 5'd0, 5'd0,  1'b0, 32'h0,        1'b0, 0, 0, 0));
    vecs.push_back(mk(32'h234, 32'h00208833, OP_ADD,     5'd1, 5'd2, 5'd16, 1'b1, 32'h0,        1'b0, 1, 1, 1));
    pops_base = n_pops;
    foreach (vecs[i]) begin
      offer(vecs[i]);
      cycle();
      chk("burst_in_ready", {31'd0, a_in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    chk("burst_throughput_pops", n_pops - pops_base, vecs.size());
    chk("burst_sb_empty", sb.size(), 32'd0);

    // RV32E instance: x16 is illegal there, x1 legal.
    offer(mk(32'h300, 32'h00208833, OP_ADD, 5'd1, 5'd2, 5'd16, 1'b1, 32'h0, 1'b0, 1, 1, 1));
    cycle();
    in_valid = 1'b0;
    chk("e_add_x16_valid", {31'd0, b_out_valid}, 32'd1);
    chk("e_add_x16_illegal", {31'd0, b_illegal}, 32'd1);
    chk("e_add_x16_op", {26'd0, b_op}, {26'd0, OP_ILLEGAL});
    chk("e_add_x16_rd_write", {31'd0, b_rd_write}, 32'd0);
    chk("e_add_x16_imm", b_imm, 32'd0);
    offer(mk(32'h304, 32'hFFF00093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1, 0, 1));
    cycle();
    in_valid = 1'b0;
    chk("e_addi_illegal", {31'd0, b_illegal}, 32'd0);
    chk("e_addi_op", {26'd0, b_op}, {26'd0, OP_ADDI});
    chk("e_addi_rd", {27'd0, b_rd}, 32'd1);
    chk("e_addi_rs1", {27'd0, b_rs1}, 32'd0);
    chk("e_addi_pc", b_out_pc, 32'h304);
    cycle();

    // Backpressure: only two accepted, then drained in order.
    out_ready = 1'b0;
    pops_base = n_pops;
    offer(mk(32'h0, 32'h00100093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h1, 1'b0, 0, 0, 1));
    cycle();
    offer(mk(32'h4, 32'h00200093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h2, 1'b0, 0, 0, 1));
    cycle();
    chk("bp_in_ready_low", {31'd0, a_in_ready}, 32'd0);
    offer(mk(32'h8, 32'h00300093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h3, 1'b0, 0, 0, 1));
    cycle();
    cycle();
    chk("bp_accepted_two", sb.size(), 32'd2);
    chk("bp_stall_valid", {31'd0, a_out_valid}, 32'd1);
    chk("bp_stall_imm", a_imm, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_acc) break;
    end
    chk("bp_pc8_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
    chk("bp_drained", sb.size(), 32'd0);
    cycle();
    chk("bp_pop_count", n_pops - pops_base, 32'd3);

    // Flush in ONE with a live same-cycle input.
    out_ready = 1'b0;
    offer(mk(32'h400, 32'h00000013, OP_ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 0, 0, 1));
    cycle();
    offer(mk(32'h404, 32'h00100093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h1, 1'b0, 0, 0, 1));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush1_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush1_in_ready", {31'd0, a_in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush in TWO with in_valid high.
    out_ready = 1'b0;
    offer(mk(32'h500, 32'h00100093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h1, 1'b0, 0, 0, 1));
    cycle();
    offer(mk(32'h504, 32'h00200093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h2, 1'b0, 0, 0, 1));
    cycle();
    chk("flush2_pre_in_ready", {31'd0, a_in_ready}, 32'd0);
    offer(mk(32'h508, 32'h00300093, OP_ADDI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h3, 1'b0, 0, 0, 1));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush2_in_ready", {31'd0, a_in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("flush2_sb_empty", sb.size(), 32'd0);

    // Asynchronous reset while holding one entry.
    out_ready = 1'b0;
    offer(mk(32'h600, 32'h123450B7, OP_LUI, 5'd0, 5'd0, 5'd1, 1'b1, 32'h12345000, 1'b0, 0, 0, 1));
    cycle();
    in_valid = 1'b0;
    chk("arst_pre_valid", {31'd0, a_out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("arst_out_pc", a_out_pc, 32'd0);
    chk("arst_out_imm", a_imm, 32'd0);
    chk("arst_out_rd", {27'd0, a_rd}, 32'd0);
    chk("arst_out_rd_write", {31'd0, a_rd_write}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) cycle();
    chk("arst_post_valid", {31'd0, a_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Parametrised RV32 decode stage with a valid/ready handshake on both sides, a two-entry skid buffer, flush, and illegal-instruction reporting. It accepts fetched `{pc, instr}` pairs and emits a decoded micro-op: operation code, register indices, write-enable and sign-extended immediate. It sits between fetch and the register-read/execute stages. Register file reads are outside this block: it outputs register indices, not register values.

## Interface
- `RV32E`, default 0: when 1, only x0–x15 exist; any rs1/rs2/rd index ≥ 16 marks the instruction illegal.
- `ENABLE_SYSTEM`, default 1: when 1, FENCE, ECALL and EBREAK decode as legal ops; when 0 they are illegal.
- `clk`  in  1  stage clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discards all buffered entries and any same-cycle input.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; driven directly from a register.
- `in_pc`  in  32  instruction address.
- `in_instr`  in  32  raw instruction word.
- `out_valid`  out  1  decoded micro-op available.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  32  pc of the emitted micro-op.
- `out_op`  out  6  `rv32_op_t` operation code.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_rd_write`  out  1  instruction writes rd and rd ≠ 0.
- `out_imm`  out  32  decoded immediate; 0 for R-type and illegal.
- `out_illegal`  out  1  encoding is not valid RV32I(E).

## Operation
- Decode is combinational from `in_instr` and is captured on accept (`in_valid && in_ready`).
- Immediate formats:
  - I: sign-extended `[31:20]`.
  - S: sign-extended `{[31:25],[11:7]}`.
  - B: sign-extended `{[31],[7],[30:25],[11:8],0}`.
  - U: `{[31:12],12'b0}`.
  - J: sign-extended `{[31],[19:12],[20],[30:21],0}`.
- Legal set:
  - LUI, AUIPC, JAL.
  - JALR with funct3 = 0.
  - Six branches.
  - LB/LH/LW/LBU/LHU.
  - SB/SH/SW.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI; SLLI and SRLI require funct7 = 0; SRAI requires funct7 = 0x20.
  - OP: ten R-type ops; funct7 = 0, except SUB/SRA which require 0x20.
  - With `ENABLE_SYSTEM` = 1: FENCE, ECALL, EBREAK.
- Illegal micro-ops are still emitted, in order, with:
  - `out_illegal` = 1
  - `out_op` = OP_ILLEGAL
  - `out_rd_write` = 0
  - `out_imm` = 0
- `out_rd_write` = 0 for branches, stores, FENCE/ECALL/EBREAK, and whenever rd = 0.
- Skid buffer states (2-bit register):
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with output fire.
  - ONE → TWO on accept with no output fire.
  - ONE → EMPTY on output fire with no accept.
  - TWO → ONE on output fire (skid entry moves to the output register); no accept is possible in TWO.
- `in_ready` = 1 in EMPTY or ONE; it is registered so it is 0 in TWO, one cycle after the second accept.
- Order is strictly FIFO. The output register always holds the older entry.
- `flush` has priority over everything: next state EMPTY, same-cycle input dropped, same-cycle output fire ignored by this block.

## Timing
- Latency: 1 cycle from accept to `out_valid` when EMPTY.
- Throughput: 1 micro-op per cycle while `out_ready` is held high.
- Reset (asynchronous assert on `rst_n` low, synchronous release): state EMPTY, `in_ready` = 1, `out_valid` = 0, all data outputs 0.
- `rst_n` asserted mid-transfer drops all entries immediately.
- Output data is stable while `out_valid && !out_ready`.
- There is no combinational path from `out_ready` to `in_ready`.
- Flush: `out_valid` = 0 and `in_ready` = 1 in the cycle after `flush`.

## Structure
- Package `rv32_decode_pkg` holds:
  - `rv32_op_t` enum: one value per legal instruction plus OP_ILLEGAL.
  - `imm_fmt_t` enum: I/S/B/U/J/NONE.
  - Opcode and funct3/funct7 constants.
  - The skid-buffer state enum.
- Sub-module `rv32_decode_comb`: purely combinational `instr → {op, rs1, rs2, rd, rd_write, imm, illegal}`, parametrised by `RV32E` and `ENABLE_SYSTEM`.
- The top level contains only the handshake and buffer state.

## Test plan
- LUI: `0x123450B7` → `out_op` = LUI, `out_rd` = 1, `out_rd_write` = 1, `out_imm` = `0x12345000`, `out_valid` one cycle after accept.
- ADDI x1,x0,-1: `0xFFF00093` → `out_imm` = `0xFFFFFFFF`, `out_rs1` = 0. SLLI with funct7 = 0x20 (`0x40101093`) → `out_illegal` = 1, `out_imm` = 0.
- Backpressure: `out_ready` = 0 while offering pcs 0x0, 0x4, 0x8 → only two accepted, `in_ready` falls after the second. Releasing `out_ready` yields 0x0, 0x4, 0x8 in order with no duplicates.
- `RV32E` = 1: ADD x16,x1,x2 (`0x00208833`) → `out_illegal` = 1. With `RV32E` = 0 the same word → ADD, `out_rd` = 16.
- Flush in state TWO, with `in_valid` high in the same cycle → next cycle `out_valid` = 0, `in_ready` = 1, and the same-cycle input never appears.
- `rst_n` pulsed low asynchronously while in ONE → `out_valid` drops immediately, `in_ready` = 1, all data outputs 0.
